// File: rtl/ctrl_cfg_writer.sv
// Control-packet table writer: decodes the control header and turns each payload beat into a table write.
// Optional build macro CTRL_MOD_FILTER_EN drops packets whose mod_id differs from STAGE_ID.
module ctrl_cfg_writer #(
    parameter int          C_S_AXIS_DATA_WIDTH  = 256,
    parameter int          C_S_AXIS_TUSER_WIDTH = 128,
    parameter int          ADDR_WIDTH           = 5,
    parameter logic [7:0]  STAGE_ID             = 8'd0
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              cfg_wr_en,
    output logic [7:0]                        cfg_mod_id,
    output logic [7:0]                        cfg_res_id,
    output logic [ADDR_WIDTH-1:0]             cfg_wr_addr,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    cfg_wr_data,
    output logic [31:0]                       cfg_pkt_cnt,
    output logic [31:0]                       cfg_err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        WRITE   = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_TOP = '1;

    state_t                           state_q, state_d;
    logic [7:0]                       mod_q, mod_d;
    logic [7:0]                       res_q, res_d;
    logic [ADDR_WIDTH-1:0]            addr_q, addr_d;
    logic                             wr_en_q, wr_en_d;
    logic [7:0]                       out_mod_q, out_mod_d;
    logic [7:0]                       out_res_q, out_res_d;
    logic [ADDR_WIDTH-1:0]            out_addr_q, out_addr_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [31:0]                      pkt_cnt_q, pkt_cnt_d;
    logic [31:0]                      err_cnt_q, err_cnt_d;

    logic [7:0] hdr_mod;
    logic [7:0] hdr_res;
    logic [7:0] hdr_index;
    logic       index_oor;
    logic       foreign_pkt;
    logic       keep_full;

    assign hdr_mod   = s_axis_tdata[128 +: 8];
    assign hdr_res   = s_axis_tdata[136 +: 8];
    assign hdr_index = s_axis_tdata[144 +: 8];
    // Index bits above the table address width must be clear; ADDR_WIDTH is assumed <= 8.
    assign index_oor = (hdr_index >> ADDR_WIDTH) != 8'd0;
    assign keep_full = (s_axis_tkeep == '1);

`ifdef CTRL_MOD_FILTER_EN
    assign foreign_pkt = (hdr_mod != STAGE_ID);
`else
    assign foreign_pkt = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{s_axis_tuser, STAGE_ID};

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            mod_q      <= '0;
            res_q      <= '0;
            addr_q     <= '0;
            wr_en_q    <= 1'b0;
            out_mod_q  <= '0;
            out_res_q  <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            mod_q      <= mod_d;
            res_q      <= res_d;
            addr_q     <= addr_d;
            wr_en_q    <= wr_en_d;
            out_mod_q  <= out_mod_d;
            out_res_q  <= out_res_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mod_d      = mod_q;
        res_d      = res_q;
        addr_d     = addr_q;
        wr_en_d    = 1'b0;
        out_mod_d  = out_mod_q;
        out_res_d  = out_res_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                    end else begin
                        state_d = HDR;
                    end
                end
            end

            HDR: begin
                if (s_axis_tvalid) begin
                    mod_d  = hdr_mod;
                    res_d  = hdr_res;
                    addr_d = hdr_index[ADDR_WIDTH-1:0];
                    // Packets for another stage are silently dropped, never counted.
                    if (foreign_pkt) begin
                        state_d = s_axis_tlast ? IDLE : DISCARD;
                    end else if (s_axis_tlast) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                        state_d   = IDLE;
                    end else if (index_oor) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                        state_d   = DISCARD;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                if (s_axis_tvalid) begin
                    if (!keep_full) begin
                        err_cnt_d = err_cnt_q + 32'd1;
                        state_d   = s_axis_tlast ? IDLE : DISCARD;
                    end else begin
                        wr_en_d    = 1'b1;
                        out_mod_d  = mod_q;
                        out_res_d  = res_q;
                        out_addr_d = addr_q;
                        out_data_d = s_axis_tdata;
                        if (s_axis_tlast) begin
                            pkt_cnt_d = pkt_cnt_q + 32'd1;
                            state_d   = IDLE;
                        end else if (addr_q == ADDR_TOP) begin
                            // Table exhausted with payload still pending; never wrap.
                            err_cnt_d = err_cnt_q + 32'd1;
                            state_d   = DISCARD;
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end
                end
            end

            DISCARD: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cfg_wr_en   = wr_en_q;
    assign cfg_mod_id  = out_mod_q;
    assign cfg_res_id  = out_res_q;
    assign cfg_wr_addr = out_addr_q;
    assign cfg_wr_data = out_data_q;
    assign cfg_pkt_cnt = pkt_cnt_q;
    assign cfg_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ctrl_cfg_writer.sv
// Scoreboard bench for ctrl_cfg_writer: packet-level reference model feeds an expected-write queue.
module tb_ctrl_cfg_writer;

    localparam int         AW    = 5;
    localparam int         DW    = 256;
    localparam int         UW    = 128;
    localparam logic [7:0] STAGE = 8'd2;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [DW/8-1:0] s_axis_tkeep = '0;
    logic [UW-1:0]   s_axis_tuser = '0;
    logic            s_axis_tvalid = 1'b0;
    logic            s_axis_tlast = 1'b0;
    logic            cfg_wr_en;
    logic [7:0]      cfg_mod_id;
    logic [7:0]      cfg_res_id;
    logic [AW-1:0]   cfg_wr_addr;
    logic [DW-1:0]   cfg_wr_data;
    logic [31:0]     cfg_pkt_cnt;
    logic [31:0]     cfg_err_cnt;

    ctrl_cfg_writer #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .ADDR_WIDTH          (AW),
        .STAGE_ID            (STAGE)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_mod_id   (cfg_mod_id),
        .cfg_res_id   (cfg_res_id),
        .cfg_wr_addr  (cfg_wr_addr),
        .cfg_wr_data  (cfg_wr_data),
        .cfg_pkt_cnt  (cfg_pkt_cnt),
        .cfg_err_cnt  (cfg_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [7:0]    mod;
        logic [7:0]    res;
        int            due;
    } exp_wr_t;

    exp_wr_t     exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_pkt = 0;
    logic [31:0] exp_err = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every strobe must match the oldest expected write, one cycle after its beat.
    initial forever begin
        exp_wr_t e;
        @(negedge clk);
        cyc++;
        if (cfg_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", cfg_wr_addr, e.addr);
                chk("wr_data", cfg_wr_data, e.data);
                chk("wr_mod",  cfg_mod_id,  e.mod);
                chk("wr_res",  cfg_res_id,  e.res);
                chk("wr_cycle", cyc, e.due);
                $display("write addr=%0d mod=%0d res=%0d at cycle %0d", cfg_wr_addr, cfg_mod_id, cfg_res_id, cyc);
            end
        end
    end

    task automatic check_counters(input string tag);
        chk({tag, "_pkt_cnt"}, cfg_pkt_cnt, exp_pkt);
        chk({tag, "_err_cnt"}, cfg_err_cnt, exp_err);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_wr_en"},   cfg_wr_en,   0);
        chk({tag, "_mod"},     cfg_mod_id,  0);
        chk({tag, "_res"},     cfg_res_id,  0);
        chk({tag, "_addr"},    cfg_wr_addr, 0);
        chk({tag, "_data"},    cfg_wr_data, 0);
        chk({tag, "_pkt_cnt"}, cfg_pkt_cnt, 0);
        chk({tag, "_err_cnt"}, cfg_err_cnt, 0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'($urandom);
        s_axis_tkeep  = $urandom;
        s_axis_tdata  = rand_beat();
    endtask

    // Sends one well-formed packet of n beats; bad >= 0 gives that beat a partial tkeep.
    task automatic send_packet(input int n, input logic [7:0] mod, input logic [7:0] res,
                               input logic [7:0] idx, input int bad, input int gmin, input int gmax);
        logic [DW-1:0]   d[16];
        logic [DW/8-1:0] keep[16];
        bit              wr[16];
        logic [AW-1:0]   wa[16];
        int              derr;
        int              dpkt;
        int              a;
        bit              foreign;
        derr = 0;
        dpkt = 0;
        for (int b = 0; b < n; b++) begin
            d[b]    = rand_beat();
            keep[b] = (b == bad) ? 32'h0000FFFF : 32'hFFFFFFFF;
            wr[b]   = 1'b0;
            wa[b]   = '0;
        end
        if (n > 1) d[1][151:128] = {idx, res, mod};
`ifdef CTRL_MOD_FILTER_EN
        foreign = (mod != STAGE);
`else
        foreign = 1'b0;
`endif
        // Reference: payload entry k lands at idx+k until a bad beat, the last beat or the table top.
        if (n == 1) derr = 1;
        else if (foreign) derr = 0;
        else if (n == 2) derr = 1;
        else if (int'(idx) >= (1 << AW)) derr = 1;
        else begin
            for (int k = 0; k < n - 2; k++) begin
                a = int'(idx) + k;
                if (keep[k+2] != 32'hFFFFFFFF) begin derr = 1; break; end
                wr[k+2] = 1'b1;
                wa[k+2] = a[AW-1:0];
                if (k + 2 == n - 1) begin dpkt = 1; break; end
                if (a == (1 << AW) - 1) begin derr = 1; break; end
            end
        end
        for (int b = 0; b < n; b++) begin
            if (b > 0) repeat ($urandom_range(gmax, gmin)) idle_cycle();
            @(posedge clk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d[b];
            s_axis_tkeep  = keep[b];
            s_axis_tlast  = (b == n - 1);
            s_axis_tuser  = {$urandom, $urandom, $urandom, $urandom};
            if (wr[b]) exp_q.push_back('{wa[b], d[b], mod, res, cyc + 2});
        end
        idle_cycle();
        repeat (2) @(posedge clk);
        #1;
        exp_pkt += 32'(dpkt);
        exp_err += 32'(derr);
        $display("packet beats=%0d mod=%0d res=%0d idx=%0d bad=%0d -> pkt=%0d err=%0d",
                 n, mod, res, idx, bad, exp_pkt, exp_err);
        check_counters("pkt");
    endtask

    // Header plus two payload beats, then a one-cycle reset while still in WRITE.
    task automatic reset_mid_write();
        logic [DW-1:0] d;
        for (int b = 0; b < 4; b++) begin
            d = rand_beat();
            if (b == 1) d[151:128] = {8'd4, 8'd7, STAGE};
            @(posedge clk); #1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = d;
            s_axis_tkeep  = 32'hFFFFFFFF;
            s_axis_tlast  = 1'b0;
            if (b >= 2) exp_q.push_back('{AW'(4 + b - 2), d, STAGE, 8'd7, cyc + 2});
        end
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        exp_pkt = 0;
        exp_err = 0;
        $display("reset pulsed mid-packet");
        check_zero("mid_reset");
        chk("mid_reset_queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        aresetn = 1'b1;

        send_packet(4, 8'd3, 8'd1, 8'd2, -1, 0, 0);
        send_packet(4, 8'd3, 8'd1, 8'd2, -1, 2, 2);
        send_packet(6, 8'd2, 8'd4, 8'd30, -1, 0, 1);
        send_packet(1, 8'd2, 8'd0, 8'd0, -1, 0, 0);
        send_packet(2, 8'd2, 8'd0, 8'd0, -1, 0, 0);
        send_packet(4, 8'd2, 8'd9, 8'd10, -1, 0, 0);
        send_packet(3, 8'd2, 8'd1, 8'd5, 2, 0, 0);
        send_packet(5, 8'd2, 8'd1, 8'd200, -1, 0, 0);
        send_packet(4, 8'd5, 8'd3, 8'd1, -1, 0, 0);
        send_packet(4, 8'd2, 8'd3, 8'd31, -1, 0, 0);

        reset_mid_write();
        send_packet(4, 8'd2, 8'd6, 8'd7, -1, 0, 1);

        for (int i = 0; i < 40; i++) begin
            int          n;
            int          bad;
            logic [7:0]  idx;
            n   = $urandom_range(8, 1);
            idx = ($urandom_range(7, 0) == 0) ? 8'($urandom) : 8'($urandom_range(31, 0));
            bad = ($urandom_range(4, 0) == 0) ? $urandom_range(n - 1, 0) : -1;
            send_packet(n, 8'($urandom_range(5, 0)), 8'($urandom), idx, bad, 0, $urandom_range(3, 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
